// File: rtl/dadda_pkg.sv
// Shared types and constants for the Dadda multiplier datapath and its MAC back-ends.
package dadda_pkg;

    // Product width is fixed by the 8x8 multiplier output.
    localparam int PROD_W        = 16;
    localparam int ACC_W_DEF     = 24;
    localparam int MAX_TERMS_DEF = 256;

    // Frame state: no terms held, frame open, result presented.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } mac_state_e;

    // Width needed to count 0..max_terms inclusive.
    function automatic int cnt_width(input int max_terms);
        return $clog2(max_terms + 1);
    endfunction

endpackage

// File: rtl/dadda_mac_acc_if.sv
// Product-in / result-out handshake bundle for the MAC back-end.
interface dadda_mac_acc_if #(
    parameter int ACC_W     = dadda_pkg::ACC_W_DEF,
    parameter int MAX_TERMS = dadda_pkg::MAX_TERMS_DEF
);
    localparam int CNT_W = dadda_pkg::cnt_width(MAX_TERMS);

    // Upstream product channel.
    logic                        prod_valid;
    logic                        prod_ready;
    logic [dadda_pkg::PROD_W-1:0] prod;
    logic                        prod_last;

    // Downstream frame-result channel.
    logic                        acc_valid;
    logic                        acc_ready;
    logic [ACC_W-1:0]            acc_out;
    logic [CNT_W-1:0]            acc_count;
    logic                        acc_ovf;

    // Accumulator side: consumes products, produces results.
    modport slave (
        input  prod_valid, prod, prod_last, acc_ready,
        output prod_ready, acc_valid, acc_out, acc_count, acc_ovf
    );

    // Environment side: produces products, consumes results.
    modport master (
        output prod_valid, prod, prod_last, acc_ready,
        input  prod_ready, acc_valid, acc_out, acc_count, acc_ovf
    );

endinterface

// File: rtl/sat_add.sv
// Combinational accumulator adder: widens by one bit to expose the carry,
// then either clamps to all-ones or wraps depending on SATURATE.
module sat_add #(
    parameter int ACC_W    = 24,
    parameter int PROD_W   = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum,
    output logic              o_carry
);

    // ACC_W must be >= PROD_W so the zero-extension pad is at least one bit.
    logic [ACC_W:0] w_sum_ext;

    assign w_sum_ext = {1'b0, i_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_prod};
    assign o_carry   = w_sum_ext[ACC_W];
    // A saturated accumulator plus any product carries again, so it stays all-ones.
    assign o_sum     = (SATURATE && o_carry) ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];

endmodule

// File: rtl/dadda_mac_acc.sv
// MAC back-end: accumulates multiplier products into a frame sum and hands
// the sum, term count and sticky overflow downstream over valid/ready.
module dadda_mac_acc
    import dadda_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter bit SATURATE  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    dadda_mac_acc_if.slave    mac_if
);

    localparam int CNT_W = cnt_width(MAX_TERMS);

    mac_state_e       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;

    logic [ACC_W-1:0] w_sum;
    logic             w_carry;
    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_close;

    sat_add #(
        .ACC_W    (ACC_W),
        .PROD_W   (PROD_W),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .i_acc   (r_acc),
        .i_prod  (mac_if.prod),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // No product is taken while a result is being presented.
    assign w_accept   = mac_if.prod_valid && (r_state != ST_HOLD);
    assign w_cnt_next = r_cnt + CNT_W'(1);
    // Explicit last and the term limit may coincide; either gives one close.
    assign w_close    = mac_if.prod_last || (w_cnt_next == CNT_W'(MAX_TERMS));

    // Frame FSM with accumulator, term count and sticky overflow.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make update order matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ACCUM: begin
                    if (w_accept) begin
                        r_acc   <= w_sum;
                        r_ovf   <= r_ovf | w_carry;
                        r_cnt   <= w_cnt_next;
                        r_state <= w_close ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    // Handoff clears the frame so the next one starts from zero.
                    if (mac_if.acc_ready) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Handshake flags are pure state decodes of the registered state.
    assign mac_if.prod_ready = (r_state != ST_HOLD);
    assign mac_if.acc_valid  = (r_state == ST_HOLD);
    assign mac_if.acc_out    = r_acc;
    assign mac_if.acc_count  = r_cnt;
    assign mac_if.acc_ovf    = r_ovf;

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Drives three MAC instances (24-bit saturating, 17-bit saturating, 17-bit
// wrapping) from one stimulus stream and compares each against a frame-level
// reference model that tracks the exact integer sum.
module tb_dadda_mac_acc;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic [15:0] s_prod;
    logic        s_last;
    logic        s_ready;

    int n_total;
    int n_bad;

    // Reference model: exact frame sum, term count, result-presented flag.
    longint m_sum;
    int     m_cnt;
    bit     m_hold;

    dadda_mac_acc_if #(.ACC_W(24), .MAX_TERMS(256)) if_d ();
    dadda_mac_acc_if #(.ACC_W(17), .MAX_TERMS(256)) if_s ();
    dadda_mac_acc_if #(.ACC_W(17), .MAX_TERMS(256)) if_w ();

    assign if_d.prod_valid = s_valid;
    assign if_d.prod       = s_prod;
    assign if_d.prod_last  = s_last;
    assign if_d.acc_ready  = s_ready;
    assign if_s.prod_valid = s_valid;
    assign if_s.prod       = s_prod;
    assign if_s.prod_last  = s_last;
    assign if_s.acc_ready  = s_ready;
    assign if_w.prod_valid = s_valid;
    assign if_w.prod       = s_prod;
    assign if_w.prod_last  = s_last;
    assign if_w.acc_ready  = s_ready;

    dadda_mac_acc #(.ACC_W(24), .MAX_TERMS(256), .SATURATE(1'b1)) u_dut_d (
        .clk(clk), .rst_n(rst_n), .mac_if(if_d));
    dadda_mac_acc #(.ACC_W(17), .MAX_TERMS(256), .SATURATE(1'b1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .mac_if(if_s));
    dadda_mac_acc #(.ACC_W(17), .MAX_TERMS(256), .SATURATE(1'b0)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .mac_if(if_w));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h want=0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected frame sum for a given width/mode from the exact integer sum.
    function automatic logic [31:0] exp_out(input int w, input bit sat);
        longint lim;
        lim = longint'(1) << w;
        if (m_sum >= lim) return sat ? 32'(lim - 1) : 32'(m_sum % lim);
        return 32'(m_sum);
    endfunction

    function automatic logic exp_ovf(input int w);
        return m_sum >= (longint'(1) << w);
    endfunction

    task automatic check_inst(input string tag, input logic pr, input logic av,
                              input logic [31:0] ao, input logic [31:0] ac,
                              input logic ov, input int w, input bit sat);
        check({tag, "/prod_ready"}, {31'd0, pr}, {31'd0, !m_hold});
        check({tag, "/acc_valid"},  {31'd0, av}, {31'd0, m_hold});
        check({tag, "/acc_out"},    ao, exp_out(w, sat));
        check({tag, "/acc_count"},  ac, 32'(m_cnt));
        check({tag, "/acc_ovf"},    {31'd0, ov}, {31'd0, exp_ovf(w)});
    endtask

    task automatic check_all(input string tag);
        check_inst({tag, "/d24s"}, if_d.prod_ready, if_d.acc_valid, 32'(if_d.acc_out),
                   32'(if_d.acc_count), if_d.acc_ovf, 24, 1'b1);
        check_inst({tag, "/d17s"}, if_s.prod_ready, if_s.acc_valid, 32'(if_s.acc_out),
                   32'(if_s.acc_count), if_s.acc_ovf, 17, 1'b1);
        check_inst({tag, "/d17w"}, if_w.prod_ready, if_w.acc_valid, 32'(if_w.acc_out),
                   32'(if_w.acc_count), if_w.acc_ovf, 17, 1'b0);
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic cycle(input string tag, input logic v, input logic [15:0] p,
                         input logic l, input logic r);
        s_valid = v;
        s_prod  = p;
        s_last  = l;
        s_ready = r;
        @(posedge clk);
        if (m_hold) begin
            if (r) begin
                m_sum  = 0;
                m_cnt  = 0;
                m_hold = 1'b0;
            end
        end else if (v) begin
            m_sum += longint'(p);
            m_cnt++;
            if (l || m_cnt == 256) m_hold = 1'b1;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    // Asynchronous reset asserted between edges and checked before any edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        m_sum  = 0;
        m_cnt  = 0;
        m_hold = 1'b0;
        #1;
        check_all({tag, "/async"});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all({tag, "/release"});
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        m_sum   = 0;
        m_cnt   = 0;
        m_hold  = 1'b0;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_prod  = '0;
        s_last  = 1'b0;
        s_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_reset("rst");

        // Basic frame: four 0xFE01 products, last on the fourth.
        for (int i = 0; i < 4; i++) cycle("basic", 1'b1, 16'hFE01, i == 3, 1'b1);
        check("basic/sum_const",   32'(if_d.acc_out),   32'h3F804);
        check("basic/count_const", 32'(if_d.acc_count), 32'd4);
        cycle("basic_hs", 1'b0, 16'h0, 1'b0, 1'b1);

        // Back-pressure: result held five cycles with prod_valid still high.
        cycle("bp", 1'b1, 16'h0010, 1'b0, 1'b0);
        cycle("bp", 1'b1, 16'h0020, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle("bp_stall", 1'b1, 16'h0001, 1'b1, 1'b0);
        check("bp/sum_const", 32'(if_d.acc_out), 32'h30);
        cycle("bp_hs", 1'b1, 16'h0001, 1'b1, 1'b1);
        cycle("bp_next", 1'b1, 16'h0001, 1'b1, 1'b0);
        check("bp_next/sum_const",   32'(if_d.acc_out),   32'd1);
        check("bp_next/count_const", 32'(if_d.acc_count), 32'd1);
        cycle("bp_next_hs", 1'b0, 16'h0, 1'b0, 1'b1);

        // Overflow at 17 bits: three 0xFE01 products.
        for (int i = 0; i < 3; i++) cycle("ovf", 1'b1, 16'hFE01, i == 2, 1'b0);
        check("ovf/sat_const",  32'(if_s.acc_out), 32'h1FFFF);
        check("ovf/wrap_const", 32'(if_w.acc_out), 32'h0FA03);
        check("ovf/flag_const", {31'd0, if_w.acc_ovf}, 32'd1);
        cycle("ovf_hs", 1'b0, 16'h0, 1'b0, 1'b1);

        // Auto-close at MAX_TERMS, then the 257th product waits for handoff.
        for (int i = 0; i < 256; i++) cycle("auto", 1'b1, 16'h0001, 1'b0, 1'b0);
        check("auto/sum_const",   32'(if_d.acc_out),   32'd256);
        check("auto/count_const", 32'(if_d.acc_count), 32'd256);
        cycle("auto_wait", 1'b1, 16'h0001, 1'b0, 1'b0);
        cycle("auto_wait", 1'b1, 16'h0001, 1'b0, 1'b0);
        cycle("auto_hs", 1'b1, 16'h0001, 1'b0, 1'b1);

        // Last flag coinciding with the term limit gives one close.
        for (int i = 0; i < 256; i++) cycle("both", 1'b1, 16'h0001, i == 255, 1'b0);
        check("both/count_const", 32'(if_d.acc_count), 32'd256);
        cycle("both_hs", 1'b0, 16'h0, 1'b0, 1'b1);
        cycle("both_idle", 1'b0, 16'h0, 1'b0, 1'b1);

        // Reset mid-frame discards the partial sum.
        for (int i = 0; i < 3; i++) cycle("midrst", 1'b1, 16'h0100, 1'b0, 1'b0);
        do_reset("midrst");
        cycle("midrst_next", 1'b1, 16'h0005, 1'b1, 1'b0);
        check("midrst/sum_const",   32'(if_d.acc_out),   32'd5);
        check("midrst/count_const", 32'(if_d.acc_count), 32'd1);
        cycle("midrst_hs", 1'b0, 16'h0, 1'b0, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
            cycle("rnd", ($urandom_range(0, 3) != 0), 16'($urandom),
                  ($urandom_range(0, 7) == 0), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
